// File: rtl/narrow_sat.sv
// 32-to-16 bit saturating narrower with a two-entry valid/ready output buffer.
// Results and their saturation flag are computed at acceptance and queued in order.
module narrow_sat #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic        sext,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] b,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  ovf_cnt
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("narrow_sat supports DEPTH == 2 only");
  end

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  state_e      state_q, state_d;
  // Each entry packs {ovf, b}; entry 0 is always the head.
  logic [16:0] ent0_q, ent0_d;
  logic [16:0] ent1_q, ent1_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] nar_b;
  logic        nar_ovf;
  logic        push;
  logic        pop;

  // Signed range check: a fits in 16 signed bits iff a[31:15] is all zeros or all ones.
  always_comb begin
    nar_b   = a[15:0];
    nar_ovf = 1'b0;
    if (sext) begin
      if (!a[31] && (a[31:15] != 17'h00000)) begin
        nar_b   = 16'h7FFF;
        nar_ovf = 1'b1;
      end else if (a[31] && (a[31:15] != 17'h1FFFF)) begin
        nar_b   = 16'h8000;
        nar_ovf = 1'b1;
      end
    end else if (a[31:16] != 16'h0000) begin
      nar_b   = 16'hFFFF;
      nar_ovf = 1'b1;
    end
  end

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          ent0_d  = {nar_ovf, nar_b};
        end
      end
      StOne: begin
        if (push && pop) begin
          ent0_d = {nar_ovf, nar_b};
        end else if (push) begin
          state_d = StFull;
          ent1_d  = {nar_ovf, nar_b};
        end else if (pop) begin
          state_d = StEmpty;
          ent0_d  = '0;
        end
      end
      StFull: begin
        if (pop) begin
          state_d = StOne;
          ent0_d  = ent1_q;
          ent1_d  = '0;
        end
      end
      default: begin
        state_d = StEmpty;
        ent0_d  = '0;
        ent1_d  = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && nar_ovf && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ent0_q  <= '0;
      ent1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign b       = out_valid ? ent0_q[15:0] : 16'h0000;
  assign ovf     = out_valid ? ent0_q[16] : 1'b0;
  assign ovf_cnt = cnt_q;

endmodule

// File: tb/tb_narrow_sat.sv
// Scoreboard bench for narrow_sat: accepted inputs queue their expected result,
// and a negedge monitor checks the head, occupancy and saturation counter.
module tb_narrow_sat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic        sext;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] b;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ovf_cnt;

  narrow_sat #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .sext      (sext),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b         (b),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] b;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  bit   mon_en   = 1'b0;
  int   rdy_mode = 0;  // 0: hold off, 1: always ready, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference narrowing done on plain integer values.
  function automatic exp_t ref_narrow(input logic [31:0] av, input logic sv);
    longint s;
    longint u;
    exp_t   r;
    s = longint'($signed(av));
    u = longint'({32'd0, av});
    r.b   = av[15:0];
    r.ovf = 1'b0;
    if (sv) begin
      if (s > 32767) begin
        r.b = 16'h7FFF; r.ovf = 1'b1;
      end else if (s < -32768) begin
        r.b = 16'h8000; r.ovf = 1'b1;
      end
    end else if (u > 65535) begin
      r.b = 16'hFFFF; r.ovf = 1'b1;
    end
    return r;
  endfunction

  // Entered and left just after a rising edge.
  task automatic send(input logic [31:0] av, input logic sv);
    int   waitc = 0;
    bit   acc   = 1'b0;
    exp_t e;
    a = av; sext = sv; in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        e = ref_narrow(av, sv);
        q.push_back(e);
        if (e.ovf && exp_cnt < 255) exp_cnt++;
      end else if (++waitc > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        acc = 1'b1;
      end
      #1;
    end
    in_valid = 1'b0;
    a = $urandom;  // stored results must not follow later input changes
    sext = 1'($urandom);
  endtask

  task automatic drain();
    int waitc = 0;
    rdy_mode = 1;
    while (q.size() != 0 && waitc < 200) begin
      @(posedge clk);
      waitc++;
    end
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_a();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 32'h0000_FFFF);
      2: return 32'hFFFF_8000 | 32'($urandom_range(0, 32'h7FFF));
      3: return 32'h0000_7FFF + 32'($urandom_range(0, 2)) - 32'd1;
      4: return 32'hFFFF_8000 + 32'($urandom_range(0, 2)) - 32'd1;
      default: return 32'h0000_FFFF + 32'($urandom_range(0, 2)) - 32'd1;
    endcase
  endfunction

  // Consumer: drives out_ready just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: occupancy, zeroed idle outputs, head compare, counter.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("occupancy", {30'd0, out_valid, in_ready},
            {30'd0, q.size() > 0, q.size() < 2});
        chk("ovf_cnt", {24'd0, ovf_cnt}, 32'(exp_cnt));
        if (!out_valid) begin
          chk("idle_zero", {15'd0, ovf, b}, 32'd0);
        end else if (q.size() > 0) begin
          e = q[0];
          chk("head", {15'd0, ovf, b}, {15'd0, e.ovf, e.b});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a = '0; sext = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {out_valid, in_ready, ovf, b, ovf_cnt}, {1'b0, 1'b1, 1'b0, 16'h0, 8'h0});
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic pass-through and signed/unsigned boundaries.
    rdy_mode = 1;
    send(32'h0000_1234, 1'b1);
    @(negedge clk);
    chk("latency_b", {15'd0, out_valid, b}, {15'd0, 1'b1, 16'h1234});
    @(posedge clk);
    #1;
    send(32'h0001_0000, 1'b1);
    send(32'hFFFF_7FFF, 1'b1);
    send(32'hFFFF_8000, 1'b1);
    drain();
    chk("signed_cnt", {24'd0, ovf_cnt}, 32'd2);
    send(32'h0000_FFFF, 1'b0);
    send(32'h8000_0000, 1'b0);
    drain();

    // Stall: two entries fill the buffer, third waits for the consumer.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    a = 32'd3; sext = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    send(32'd3, 1'b0);
    drain();

    // Counter saturation.
    for (int i = 0; i < 300; i++) send(32'h0001_0000 + 32'(i), 1'b1);
    drain();
    chk("cnt_saturated", {24'd0, ovf_cnt}, 32'hFF);

    // Reset while full discards contents.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(32'h8000_0000, 1'b1);
    send(32'h0000_0005, 1'b1);
    @(negedge clk);
    chk("full_before_rst", {30'd0, out_valid, in_ready}, 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    q.delete();
    exp_cnt = 0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_full", {out_valid, in_ready, ovf, b, ovf_cnt}, {1'b0, 1'b1, 1'b0, 16'h0, 8'h0});
    @(posedge clk);
    #1;

    // Random traffic with random consumer backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(rand_a(), 1'($urandom_range(0, 1)));
    end
    drain();
    chk("final_cnt", {24'd0, ovf_cnt}, 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
